scan_sequencer: RTL and testbench

- Sequences one antenna scan: rotate N motor steps, settle, then sweep the four RF switch paths, firing one ADC conversion per path; repeat for every angular point.
- Sits between the button edge-triggers and clock divider (inputs) and the stepper, RF switch and ADC trigger pins (outputs).
- Provides the step-enable timing for the existing motor and ADC trigger gating.
- All logic is on the 50 MHz fabric clock; slow timing comes from one-cycle tick enables, never derived clocks.

---
 rtl/scan_sequencer_pkg.sv | 39 +++
 rtl/scan_sequencer_if.sv | 33 +++
 rtl/scan_sequencer_timer.sv | 30 +++
 rtl/scan_sequencer.sv | 205 ++++++++++++++++++++
 tb/tb_scan_sequencer.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scan_sequencer_pkg.sv
// Shared types and constants for the antenna scan sequencer.
// Holds the FSM state encoding and the RF path one-hot selects.
package scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ROTATE,
        SETTLE,
        SELECT,
        TRIG,
        WAIT_ADC,
        NEXT,
        DONE
    } state_t;

    localparam int unsigned RF_PATHS = 4;

    localparam logic [RF_PATHS-1:0] RF_PATH0 = 4'b0001;
    localparam logic [RF_PATHS-1:0] RF_PATH1 = 4'b0010;
    localparam logic [RF_PATHS-1:0] RF_PATH2 = 4'b0100;
    localparam logic [RF_PATHS-1:0] RF_PATH3 = 4'b1000;

    // Wide enough for the ADC timeout count.
    localparam int unsigned TMR_W = 16;

    function automatic logic [RF_PATHS-1:0] rf_onehot(input logic [1:0] idx);
        logic [RF_PATHS-1:0] sel;
        sel = RF_PATH0;
        case (idx)
            2'd0: sel = RF_PATH0;
            2'd1: sel = RF_PATH1;
            2'd2: sel = RF_PATH2;
            2'd3: sel = RF_PATH3;
            default: sel = RF_PATH0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/scan_sequencer_if.sv
// Control/status bundle between the scan sequencer and its surroundings.
// master drives the stimulus side (buttons, tick, ADC), slave is the sequencer.
interface scan_sequencer_if #(
    parameter int unsigned ANG_W = 10
);
    import scan_pkg::*;

    logic                start;
    logic                abort;
    logic                stp_tick;
    logic [3:0]          cfg_steps;
    logic [ANG_W-1:0]    cfg_points;
    logic                adc_done;

    logic                rot_step;
    logic [RF_PATHS-1:0] rf_sw;
    logic                adc_trg;
    logic                busy;
    logic                scan_done;
    logic [ANG_W-1:0]    rot_count;
    logic                err_tmo;

    modport master (
        output start, abort, stp_tick, cfg_steps, cfg_points, adc_done,
        input  rot_step, rf_sw, adc_trg, busy, scan_done, rot_count, err_tmo
    );

    modport slave (
        input  start, abort, stp_tick, cfg_steps, cfg_points, adc_done,
        output rot_step, rf_sw, adc_trg, busy, scan_done, rot_count, err_tmo
    );

endinterface

// File: rtl/scan_sequencer_timer.sv
// Loadable down-counter with count enable and a zero flag.
// Load wins over enable; the count parks at zero.
module seq_timer
    import scan_pkg::*;
#(
    parameter int unsigned W = TMR_W
) (
    input  logic         fpga_clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    input  logic         i_en,
    output logic         o_zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge fpga_clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/scan_sequencer.sv
// Antenna scan sequencer: rotate, settle, then sweep four RF paths with one
// ADC conversion each, for every angular point. All outputs are registered.
module scan_sequencer
    import scan_pkg::*;
#(
    parameter int unsigned ANG_W        = 10,
    parameter int unsigned SETTLE_TICKS = 3,
    parameter int unsigned GUARD_CLKS   = 50,
    parameter int unsigned ADC_TMO      = 5000
) (
    input logic        fpga_clk,
    input logic        rst,
    scan_sequencer_if.slave bus
);

    // Timer is loaded with N-1 and the terminal event fires on the zero count.
    localparam logic [TMR_W-1:0] SETTLE_M1 = TMR_W'(SETTLE_TICKS - 1);
    localparam logic [TMR_W-1:0] GUARD_M1  = TMR_W'(GUARD_CLKS - 1);
    localparam logic [TMR_W-1:0] TMO_M1    = TMR_W'(ADC_TMO - 1);

    state_t              r_state, w_state_d;
    logic [3:0]          r_steps_m1, w_steps_m1_d;
    logic [ANG_W-1:0]    r_points, w_points_d;
    logic [ANG_W-1:0]    r_rot_count, w_rot_count_d;
    logic [1:0]          r_rf_idx, w_rf_idx_d;
    logic [RF_PATHS-1:0] r_rf_sw, w_rf_sw_d;
    logic                r_busy, w_busy_d;
    logic                r_rot_step, w_rot_step_d;
    logic                r_adc_trg, w_adc_trg_d;
    logic                r_scan_done, w_scan_done_d;
    logic                r_err_tmo, w_err_tmo_d;

    logic                w_tmr_load;
    logic [TMR_W-1:0]    w_tmr_val;
    logic                w_tmr_en;
    logic                w_tmr_zero;
    logic [3:0]          w_steps_in_m1;

    // A step count of zero behaves as one step.
    assign w_steps_in_m1 = (bus.cfg_steps == 4'd0) ? 4'd0 : (bus.cfg_steps - 4'd1);

    seq_timer #(
        .W (TMR_W)
    ) u_timer (
        .fpga_clk   (fpga_clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_en       (w_tmr_en),
        .o_zero     (w_tmr_zero)
    );

    always_comb begin
        w_state_d     = r_state;
        w_steps_m1_d  = r_steps_m1;
        w_points_d    = r_points;
        w_rot_count_d = r_rot_count;
        w_rf_idx_d    = r_rf_idx;
        w_rf_sw_d     = r_rf_sw;
        w_busy_d      = r_busy;
        w_err_tmo_d   = r_err_tmo;
        w_rot_step_d  = 1'b0;
        w_adc_trg_d   = 1'b0;
        w_scan_done_d = 1'b0;
        w_tmr_load    = 1'b0;
        w_tmr_val     = '0;
        w_tmr_en      = 1'b0;

        if ((r_state != IDLE) && bus.abort) begin
            w_state_d = IDLE;
            w_rf_sw_d = '0;
            w_busy_d  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start && !bus.abort) begin
                        w_steps_m1_d  = w_steps_in_m1;
                        w_points_d    = bus.cfg_points;
                        w_rot_count_d = '0;
                        w_rf_idx_d    = '0;
                        w_err_tmo_d   = 1'b0;
                        w_busy_d      = 1'b1;
                        w_tmr_load    = 1'b1;
                        w_tmr_val     = {{(TMR_W-4){1'b0}}, w_steps_in_m1};
                        w_state_d     = (bus.cfg_points == '0) ? DONE : ROTATE;
                    end
                end

                ROTATE: begin
                    w_tmr_en = bus.stp_tick;
                    if (bus.stp_tick) begin
                        w_rot_step_d = 1'b1;
                        if (w_tmr_zero) begin
                            w_tmr_load = 1'b1;
                            w_tmr_val  = SETTLE_M1;
                            w_state_d  = SETTLE;
                        end
                    end
                end

                SETTLE: begin
                    w_tmr_en = bus.stp_tick;
                    if (bus.stp_tick && w_tmr_zero) begin
                        w_rf_idx_d = 2'd0;
                        w_rf_sw_d  = rf_onehot(2'd0);
                        w_tmr_load = 1'b1;
                        w_tmr_val  = GUARD_M1;
                        w_state_d  = SELECT;
                    end
                end

                SELECT: begin
                    w_tmr_en = 1'b1;
                    if (w_tmr_zero) begin
                        w_adc_trg_d = 1'b1;
                        w_state_d   = TRIG;
                    end
                end

                TRIG: begin
                    w_tmr_load = 1'b1;
                    w_tmr_val  = TMO_M1;
                    w_state_d  = WAIT_ADC;
                end

                WAIT_ADC: begin
                    w_tmr_en = 1'b1;
                    if (bus.adc_done) begin
                        w_state_d = NEXT;
                    end else if (w_tmr_zero) begin
                        w_err_tmo_d = 1'b1;
                        w_state_d   = NEXT;
                    end
                end

                NEXT: begin
                    if (r_rf_idx != 2'd3) begin
                        w_rf_idx_d = r_rf_idx + 2'd1;
                        w_rf_sw_d  = rf_onehot(r_rf_idx + 2'd1);
                        w_tmr_load = 1'b1;
                        w_tmr_val  = GUARD_M1;
                        w_state_d  = SELECT;
                    end else begin
                        w_rf_sw_d = '0;
                        if (r_rot_count == (r_points - 1'b1)) begin
                            w_state_d = DONE;
                        end else begin
                            w_rot_count_d = r_rot_count + 1'b1;
                            w_tmr_load    = 1'b1;
                            w_tmr_val     = {{(TMR_W-4){1'b0}}, r_steps_m1};
                            w_state_d     = ROTATE;
                        end
                    end
                end

                DONE: begin
                    w_scan_done_d = 1'b1;
                    w_busy_d      = 1'b0;
                    w_state_d     = IDLE;
                end

                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge fpga_clk or negedge rst) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_steps_m1  <= '0;
            r_points    <= '0;
            r_rot_count <= '0;
            r_rf_idx    <= '0;
            r_rf_sw     <= '0;
            r_busy      <= 1'b0;
            r_rot_step  <= 1'b0;
            r_adc_trg   <= 1'b0;
            r_scan_done <= 1'b0;
            r_err_tmo   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_steps_m1  <= w_steps_m1_d;
            r_points    <= w_points_d;
            r_rot_count <= w_rot_count_d;
            r_rf_idx    <= w_rf_idx_d;
            r_rf_sw     <= w_rf_sw_d;
            r_busy      <= w_busy_d;
            r_rot_step  <= w_rot_step_d;
            r_adc_trg   <= w_adc_trg_d;
            r_scan_done <= w_scan_done_d;
            r_err_tmo   <= w_err_tmo_d;
        end
    end

    assign bus.rot_step  = r_rot_step;
    assign bus.rf_sw     = r_rf_sw;
    assign bus.adc_trg   = r_adc_trg;
    assign bus.busy      = r_busy;
    assign bus.scan_done = r_scan_done;
    assign bus.rot_count = r_rot_count;
    assign bus.err_tmo   = r_err_tmo;

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: scoreboard queues hold the expected rf_sw
// at each adc_trg and rot_count at each rot_step; outputs sampled on negedge.
module tb_scan_sequencer;

    localparam int unsigned ANG_W        = 10;
    localparam int unsigned SETTLE_TICKS = 3;
    localparam int unsigned GUARD_CLKS   = 50;
    localparam int unsigned ADC_TMO      = 5000;
    localparam int          TRG_GAP      = GUARD_CLKS + ADC_TMO + 2;

    logic fpga_clk    = 1'b0;
    logic rst         = 1'b0;
    logic adc_resp_en = 1'b0;
    logic adc_kick    = 1'b0;
    logic gap_chk     = 1'b0;
    logic gap_valid   = 1'b0;

    int n_tests  = 0;
    int n_fail   = 0;
    int n_step   = 0;
    int n_trg    = 0;
    int n_done   = 0;
    int cyc      = 0;
    int last_trg = 0;
    int tick_div = 0;
    int adc_cnt  = 0;
    int s_step, s_trg, s_done;

    logic [3:0]       exp_rf[$];
    logic [ANG_W-1:0] exp_rot[$];

    scan_sequencer_if #(.ANG_W(ANG_W)) bus ();

    scan_sequencer #(
        .ANG_W        (ANG_W),
        .SETTLE_TICKS (SETTLE_TICKS),
        .GUARD_CLKS   (GUARD_CLKS),
        .ADC_TMO      (ADC_TMO)
    ) dut (
        .fpga_clk (fpga_clk),
        .rst      (rst),
        .bus      (bus)
    );

    always #10 fpga_clk = ~fpga_clk;

    // Step-rate enable: one cycle in eight.
    initial begin
        bus.stp_tick = 1'b0;
        forever begin
            @(negedge fpga_clk);
            tick_div = (tick_div == 7) ? 0 : tick_div + 1;
            bus.stp_tick = (tick_div == 0);
        end
    end

    // ADC model: answers 10 cycles after each trigger when enabled.
    initial begin
        bus.adc_done = 1'b0;
        forever begin
            @(negedge fpga_clk);
            bus.adc_done = adc_kick || (adc_cnt == 1);
            if (adc_cnt != 0) adc_cnt--;
            if (bus.adc_trg && adc_resp_en) adc_cnt = 10;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [3:0]       e_rf;
        logic [ANG_W-1:0] e_rot;
        @(negedge fpga_clk);
        cyc++;
        if (bus.rot_step) begin
            n_step++;
            e_rot = (exp_rot.size() != 0) ? exp_rot.pop_front() : '1;
            check("rot_count_at_step", 32'(bus.rot_count), 32'(e_rot));
        end
        if (bus.adc_trg) begin
            n_trg++;
            e_rf = (exp_rf.size() != 0) ? exp_rf.pop_front() : 4'hF;
            check("rf_sw_at_trg", 32'(bus.rf_sw), 32'(e_rf));
            if (gap_chk && gap_valid) check("trg_gap", 32'(cyc - last_trg), 32'(TRG_GAP));
            last_trg  = cyc;
            gap_valid = gap_chk;
        end
        if (bus.scan_done) n_done++;
    endtask

    task automatic snap();
        s_step = n_step;
        s_trg  = n_trg;
        s_done = n_done;
    endtask

    task automatic push_scan(input int points, input int steps_eff, input int trgs);
        for (int p = 0; p < points; p++)
            for (int s = 0; s < steps_eff; s++) exp_rot.push_back(ANG_W'(p));
        for (int t = 0; t < trgs; t++) exp_rf.push_back(4'b0001 << (t % 4));
    endtask

    task automatic start_scan(input logic [3:0] steps, input logic [ANG_W-1:0] points);
        bus.cfg_steps  = steps;
        bus.cfg_points = points;
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_after_start", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (!bus.scan_done && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(bus.scan_done), 32'd1);
    endtask

    task automatic wait_trg(input int target, input int budget, input string tag);
        int k = 0;
        while (n_trg < target && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(n_trg >= target), 32'd1);
    endtask

    task automatic wait_step(input int target, input int budget, input string tag);
        int k = 0;
        while (n_step < target && k < budget) begin
            step();
            k++;
        end
        check(tag, 32'(n_step >= target), 32'd1);
    endtask

    initial begin
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        bus.cfg_steps  = 4'd0;
        bus.cfg_points = '0;

        // Reset state
        repeat (3) step();
        check("reset_outputs", 32'({bus.busy, bus.rot_step, bus.adc_trg, bus.scan_done,
                                    bus.err_tmo, bus.rf_sw, bus.rot_count}), 32'd0);
        rst = 1'b1;
        step();
        check("idle_after_reset", 32'(bus.busy), 32'd0);

        // Basic scan: 2 steps x 3 points
        adc_resp_en = 1'b1;
        snap();
        push_scan(3, 2, 12);
        start_scan(4'd2, ANG_W'(3));
        wait_done(4000, "basic_done");
        check("basic_busy_at_done", 32'(bus.busy), 32'd0);
        check("basic_rot_count", 32'(bus.rot_count), 32'd2);
        check("basic_rf_idle", 32'(bus.rf_sw), 32'd0);
        repeat (5) step();
        check("basic_steps", 32'(n_step - s_step), 32'd6);
        check("basic_trgs", 32'(n_trg - s_trg), 32'd12);
        check("basic_dones", 32'(n_done - s_done), 32'd1);
        check("basic_rf_q_empty", 32'(exp_rf.size()), 32'd0);
        check("basic_rot_q_empty", 32'(exp_rot.size()), 32'd0);
        check("basic_rot_count_hold", 32'(bus.rot_count), 32'd2);

        // Empty scan: scan_done two cycles after start
        snap();
        start_scan(4'd1, ANG_W'(0));
        step();
        check("empty_done_latency", 32'(bus.scan_done), 32'd1);
        repeat (5) step();
        check("empty_steps", 32'(n_step - s_step), 32'd0);
        check("empty_trgs", 32'(n_trg - s_trg), 32'd0);
        check("empty_busy", 32'(bus.busy), 32'd0);

        // cfg_steps = 0 behaves as one step per point
        snap();
        push_scan(2, 1, 8);
        start_scan(4'd0, ANG_W'(2));
        wait_done(4000, "steps0_done");
        check("steps0_steps", 32'(n_step - s_step), 32'd2);
        check("steps0_trgs", 32'(n_trg - s_trg), 32'd8);

        // ADC timeout: no adc_done at all
        adc_resp_en = 1'b0;
        gap_chk     = 1'b1;
        snap();
        push_scan(1, 1, 4);
        start_scan(4'd1, ANG_W'(1));
        wait_done(25000, "tmo_done");
        gap_chk = 1'b0;
        check("tmo_err_set", 32'(bus.err_tmo), 32'd1);
        check("tmo_trgs", 32'(n_trg - s_trg), 32'd4);
        check("tmo_dones", 32'(n_done - s_done), 32'd1);
        repeat (5) step();
        check("tmo_err_sticky", 32'(bus.err_tmo), 32'd1);

        // Abort during WAIT_ADC at point 1, rf_idx 2
        adc_resp_en = 1'b1;
        snap();
        push_scan(2, 1, 7);
        start_scan(4'd1, ANG_W'(2));
        check("start_clears_err", 32'(bus.err_tmo), 32'd0);
        wait_trg(s_trg + 7, 4000, "abort_reach_trg");
        repeat (5) step();
        check("pre_abort_rf", 32'(bus.rf_sw), 32'b0100);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        check("abort_rf_sw", 32'(bus.rf_sw), 32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        check("abort_no_done", 32'(bus.scan_done), 32'd0);
        adc_kick = 1'b1;
        step();
        adc_kick = 1'b0;
        repeat (30) step();
        check("abort_still_idle", 32'(bus.busy), 32'd0);
        check("abort_trgs", 32'(n_trg - s_trg), 32'd7);
        check("abort_dones", 32'(n_done - s_done), 32'd0);

        // Fresh start after abort, then start while busy is ignored
        snap();
        push_scan(1, 1, 4);
        start_scan(4'd1, ANG_W'(1));
        check("restart_rot_count", 32'(bus.rot_count), 32'd0);
        repeat (40) step();
        bus.cfg_points = ANG_W'(5);
        bus.start      = 1'b1;
        step();
        bus.start = 1'b0;
        check("busy_start_busy", 32'(bus.busy), 32'd1);
        wait_done(4000, "busy_start_done");
        repeat (30) step();
        check("busy_start_steps", 32'(n_step - s_step), 32'd1);
        check("busy_start_trgs", 32'(n_trg - s_trg), 32'd4);
        check("busy_start_dones", 32'(n_done - s_done), 32'd1);
        check("busy_start_idle", 32'(bus.busy), 32'd0);

        // Start and abort together in IDLE
        snap();
        bus.cfg_points = ANG_W'(1);
        bus.start      = 1'b1;
        bus.abort      = 1'b1;
        step();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", 32'(bus.busy), 32'd0);
        repeat (20) step();
        check("start_abort_steps", 32'(n_step - s_step), 32'd0);
        check("start_abort_still_idle", 32'(bus.busy), 32'd0);

        // Reset mid-ROTATE
        snap();
        push_scan(1, 15, 0);
        start_scan(4'd15, ANG_W'(1));
        wait_step(s_step + 1, 200, "rst_reach_rotate");
        check("rst_pre_busy", 32'(bus.busy), 32'd1);
        #2 rst = 1'b0;
        #1 check("rst_async_outputs", 32'({bus.busy, bus.rot_step, bus.adc_trg, bus.scan_done,
                                           bus.err_tmo, bus.rf_sw, bus.rot_count}), 32'd0);
        repeat (3) step();
        rst = 1'b1;
        exp_rot.delete();
        snap();
        repeat (40) step();
        check("rst_idle_busy", 32'(bus.busy), 32'd0);
        check("rst_idle_steps", 32'(n_step - s_step), 32'd0);
        check("rst_idle_rf", 32'(bus.rf_sw), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
